// File: rtl/bi_gr_cnt.sv
// Registered binary counter with a registered Gray-coded copy and a wrap pulse.
// Define BI_GR_CNT_BIN_OUT_EN to also expose the registered binary count on `bin`.
module bi_gr_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
`ifdef BI_GR_CNT_BIN_OUT_EN
    output logic [WIDTH-1:0] bin,
`endif
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (en && up) begin
            cnt_d  = cnt_q + 1'b1;
            wrap_d = (cnt_q == '1);
        end else if (en) begin
            cnt_d  = cnt_q - 1'b1;
            wrap_d = (cnt_q == '0);
        end
        // Gray is built from the next count so it lands in the same cycle as cnt.
        gray_d = cnt_d ^ (cnt_d >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign gray = gray_q;
    assign wrap = wrap_q;
`ifdef BI_GR_CNT_BIN_OUT_EN
    assign bin  = cnt_q;
`endif

endmodule

// File: tb/tb_bi_gr_cnt.sv
// Scoreboard bench for bi_gr_cnt (WIDTH=4): expected values queued on drive, checked after the edge.
module tb_bi_gr_cnt;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] gray;
    logic         wrap;
`ifdef BI_GR_CNT_BIN_OUT_EN
    logic [W-1:0] bin;
`endif

    always #5 clk = ~clk;

    bi_gr_cnt #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .gray     (gray),
`ifdef BI_GR_CNT_BIN_OUT_EN
        .bin      (bin),
`endif
        .wrap     (wrap)
    );

    typedef struct {
        logic [W-1:0] g;
        logic         w;
        logic [W-1:0] b;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_cnt;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Drive one cycle of inputs, predict, then compare after the rising edge.
    task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] lv);
        exp_t x;
        logic wr;
        @(negedge clk);
        en = e; up = u; load = l; load_val = lv;
        wr = 1'b0;
        if (l) begin
            m_cnt = lv;
        end else if (e && u) begin
            wr    = (m_cnt == 4'hF);
            m_cnt = m_cnt + 4'd1;
        end else if (e) begin
            wr    = (m_cnt == 4'h0);
            m_cnt = m_cnt - 4'd1;
        end
        x.g = g2b_inv(m_cnt);
        x.w = wr;
        x.b = m_cnt;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            chk("gray", gray, x.g);
            chk("wrap", wrap, x.w);
`ifdef BI_GR_CNT_BIN_OUT_EN
            chk("bin", bin, x.b);
`endif
        end
    endtask

    // Binary-to-Gray by table walk: bit i flips whenever bits i and i+1 of the count differ.
    function automatic logic [W-1:0] g2b_inv(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = 0; i < W - 1; i++) g[i] = b[i] ^ b[i+1];
        return g;
    endfunction

    logic [W-1:0] up_seq [5];
    logic [W-1:0] prev;

    initial begin
        up_seq[0] = 4'b0001; up_seq[1] = 4'b0011; up_seq[2] = 4'b0010;
        up_seq[3] = 4'b0110; up_seq[4] = 4'b0111;

        rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
        m_cnt = '0;
        #1;
        chk("rst_gray0", gray, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_gray", gray, 4'b0000);
            chk("rst_wrap", wrap, 1'b0);
`ifdef BI_GR_CNT_BIN_OUT_EN
            chk("rst_bin", bin, 4'b0000);
`endif
        end
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            chk("up_seq", gray, up_seq[i]);
            chk("up_nowrap", wrap, 1'b0);
        end

        step(1'b0, 1'b0, 1'b1, 4'hF);
        chk("load_f_gray", gray, 4'b1000);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("upwrap_gray", gray, 4'b0000);
        chk("upwrap_wrap", wrap, 1'b1);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("upwrap_next_gray", gray, 4'b0001);
        chk("upwrap_next_wrap", wrap, 1'b0);

        step(1'b0, 1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("dnwrap_gray", gray, 4'b1000);
        chk("dnwrap_wrap", wrap, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("dnwrap_next_gray", gray, 4'b1001);
        chk("dnwrap_next_wrap", wrap, 1'b0);

        step(1'b0, 1'b1, 1'b0, '0);
        chk("hold_gray", gray, 4'b1001);

        step(1'b1, 1'b1, 1'b1, 4'b1001);
        chk("loadpri_gray", gray, 4'b1101);
        chk("loadpri_wrap", wrap, 1'b0);

        step(1'b0, 1'b0, 1'b1, 4'hF);
        step(1'b1, 1'b1, 1'b1, 4'h0);
        chk("load_nowrap", wrap, 1'b0);

        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_gray", gray, 4'b0000);
        chk("midrst_wrap", wrap, 1'b0);
`ifdef BI_GR_CNT_BIN_OUT_EN
        chk("midrst_bin", bin, 4'b0000);
`endif
        m_cnt = '0;
        en = 1'b0; load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        prev = gray;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            chk("full_decode", g2b(gray), m_cnt);
`ifdef BI_GR_CNT_BIN_OUT_EN
            chk("full_bin", g2b(gray), bin);
`endif
            chk("full_onebit", $countones(gray ^ prev), 1);
            prev = gray;
        end

        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
